// File: rtl/disp_7_seg_arbiter.sv
// rtl/disp_7_seg_arbiter.sv - round-robin arbiter sharing a 4-digit 7-segment display
//
// Purpose: grants the display to one of NREQ requesters at a time, holding each
// grant for at least HOLD_CYCLES clocks, and forwards the owner's 16-bit value
// to the display controller digit inputs.
// Optional feature macro: DISP_ARB_PRIO0_EN (requester 0 preempts other owners).
//
// Ports:
//   clk       system clock (10 MHz)
//   rst       asynchronous active-high reset
//   req       per-requester level request
//   data      requester i value at data[16*i+15:16*i], nibble 0 = rightmost digit
//   grant     one-hot grant, zero when idle or lingering
//   owner_id  index of current or last owner
//   busy      high while a grant or linger period is active
//   hex0..3   digit nibbles to the display controller
module disp_7_seg_arbiter #(
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 10000000,
  parameter int CW          = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   data,
  output logic [NREQ-1:0]      grant,
  output logic [1:0]           owner_id,
  output logic                 busy,
  output logic [3:0]           hex0,
  output logic [3:0]           hex1,
  output logic [3:0]           hex2,
  output logic [3:0]           hex3
);

  typedef enum logic [1:0] {IDLE, OWNED, LINGER} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx, cnt_inc;
  logic [1:0]      ptr, ptr_nx;
  logic [NREQ-1:0] grant_nx;
  logic [1:0]      owner_nx;
  logic [15:0]     hex_q, hex_nx;

  // Requests and data padded to the maximum of four requesters so every
  // 2-bit index is in range regardless of NREQ.
  logic [3:0]  req4;
  logic [63:0] data4;

  logic        arb_found;
  logic [1:0]  arb_win;
  logic        expired, owner_req, others, take;

  function automatic logic [15:0] sel_data(input logic [63:0] d, input logic [1:0] i);
    return d[{i, 4'b0000} +: 16];
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] i);
    logic [3:0] t;
    t = onehot4(i);
    return t[NREQ-1:0];
  endfunction

  always_comb begin
    req4             = '0;
    req4[NREQ-1:0]   = req;
    data4            = '0;
    data4[16*NREQ-1:0] = data;
  end

  // Round-robin search starting just after the last winner, wrapping mod NREQ.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [2:0] s;
      s = {1'b0, ptr} + 3'(k);
      if (s >= 3'(NREQ)) s = s - 3'(NREQ);
      if (!arb_found && req4[s[1:0]]) begin
        arb_found = 1'b1;
        arb_win   = s[1:0];
      end
    end
  end

  assign cnt_inc   = (cnt == CW'(HOLD_CYCLES)) ? cnt : cnt + 1'b1;
  assign expired   = (cnt >= CW'(HOLD_CYCLES - 1));
  assign owner_req = req4[owner_id];
  assign others    = |(req4 & ~onehot4(owner_id));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    grant_nx = grant;
    owner_nx = owner_id;
    hex_nx   = hex_q;
    take     = 1'b0;

    case (state)
      IDLE: begin
        grant_nx = '0;
        if (arb_found) take = 1'b1;
      end
      OWNED: begin
        cnt_nx = cnt_inc;
        hex_nx = sel_data(data4, owner_id);
        if (!expired) begin
          if (!owner_req) begin
            state_nx = LINGER;
            grant_nx = '0;
            hex_nx   = hex_q;
          end
        end else if (others) begin
          // Pointer equals the owner, so the owner is searched last and
          // another pending requester always wins here.
          take = 1'b1;
        end else if (!owner_req) begin
          state_nx = IDLE;
          grant_nx = '0;
          hex_nx   = hex_q;
        end
      end
      LINGER: begin
        cnt_nx   = cnt_inc;
        grant_nx = '0;
        if (expired) begin
          if (arb_found) take = 1'b1;
          else           state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase

    if (take) begin
      state_nx = OWNED;
      grant_nx = onehot(arb_win);
      owner_nx = arb_win;
      hex_nx   = sel_data(data4, arb_win);
      cnt_nx   = '0;
      ptr_nx   = arb_win;
    end

`ifdef DISP_ARB_PRIO0_EN
    // Urgent requester 0 overrides any other owner or lingerer at once.
    if (state != IDLE && owner_id != 2'd0 && req[0]) begin
      state_nx = OWNED;
      grant_nx = onehot(2'd0);
      owner_nx = 2'd0;
      hex_nx   = sel_data(data4, 2'd0);
      cnt_nx   = '0;
      ptr_nx   = 2'd0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= 2'(NREQ - 1);
      grant    <= '0;
      owner_id <= '0;
      busy     <= 1'b0;
      hex_q    <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ptr      <= ptr_nx;
      grant    <= grant_nx;
      owner_id <= owner_nx;
      busy     <= (state_nx != IDLE);
      hex_q    <= hex_nx;
    end
  end

  assign hex0 = hex_q[3:0];
  assign hex1 = hex_q[7:4];
  assign hex2 = hex_q[11:8];
  assign hex3 = hex_q[15:12];

endmodule

// File: tb/tb_disp_7_seg_arbiter.sv
// tb/tb_disp_7_seg_arbiter.sv - directed self-checking bench for disp_7_seg_arbiter
module tb_disp_7_seg_arbiter;

  localparam int NREQ = 3;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [47:0]      data;
  logic [NREQ-1:0]  grant;
  logic [1:0]       owner_id;
  logic             busy;
  logic [3:0]       hex0, hex1, hex2, hex3;

  int checks;
  int failures;

  disp_7_seg_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(8), .CW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .grant    (grant),
    .owner_id (owner_id),
    .busy     (busy),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] hexv;
    return {16'h0, hex3, hex2, hex1, hex0};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = '0;
    data     = '0;
    tick();
    check_eq("rst_owner", {30'h0, owner_id}, 32'd0);
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("idle_grant", {29'h0, grant}, 32'd0);
      check_eq("idle_busy", {31'h0, busy}, 32'd0);
      check_eq("idle_hex", hexv(), 32'h0);
    end

    // Single requester, live data tracking, indefinite hold, async reset
    do_reset();
    data[31:16] = 16'h1234;
    req = 3'b010;
    tick();
    check_eq("g1_grant", {29'h0, grant}, 32'b010);
    check_eq("g1_owner", {30'h0, owner_id}, 32'd1);
    check_eq("g1_busy", {31'h0, busy}, 32'd1);
    check_eq("g1_hex", hexv(), 32'h1234);
    data[31:16] = 16'hBEEF;
    tick();
    check_eq("g1_live_hex", hexv(), 32'hBEEF);
    for (int i = 0; i < 12; i++) tick();
    check_eq("g1_stay_grant", {29'h0, grant}, 32'b010);
    rst = 1'b1;
    #1;
    check_eq("async_grant", {29'h0, grant}, 32'd0);
    check_eq("async_busy", {31'h0, busy}, 32'd0);
    check_eq("async_owner", {30'h0, owner_id}, 32'd0);
    check_eq("async_hex", hexv(), 32'h0);
    rst = 1'b0;

    // All requesting: strict round-robin, 8 cycles each, no idle gap
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 32; i++) begin
      logic [2:0] e;
      tick();
      e = 3'b001 << ((i / 8) % 3);
      check_eq("rr_grant", {29'h0, grant}, {29'h0, e});
    end

    // Short pulse then linger with frozen hex
    do_reset();
    data[47:32] = 16'h00A5;
    req = 3'b100;
    tick();
    check_eq("pl_grant1", {29'h0, grant}, 32'b100);
    check_eq("pl_hex1", hexv(), 32'h00A5);
    tick();
    tick();
    check_eq("pl_grant3", {29'h0, grant}, 32'b100);
    req = 3'b000;
    tick();
    check_eq("pl_linger_grant", {29'h0, grant}, 32'd0);
    check_eq("pl_linger_busy", {31'h0, busy}, 32'd1);
    data[47:32] = 16'hFFFF;
    for (int i = 5; i <= 8; i++) begin
      tick();
      check_eq("pl_linger_busy", {31'h0, busy}, 32'd1);
      check_eq("pl_linger_grant", {29'h0, grant}, 32'd0);
      check_eq("pl_linger_hex", hexv(), 32'h00A5);
    end
    tick();
    check_eq("pl_idle_busy", {31'h0, busy}, 32'd0);
    check_eq("pl_idle_hex", hexv(), 32'h00A5);

    // New request mid-hold waits for expiry
    do_reset();
    req = 3'b010;
    tick();
    tick();
    tick();
    req = 3'b110;
    for (int i = 4; i <= 8; i++) begin
      tick();
      check_eq("mh_hold_grant", {29'h0, grant}, 32'b010);
    end
    tick();
    check_eq("mh_exp_grant", {29'h0, grant}, 32'b100);
    check_eq("mh_exp_owner", {30'h0, owner_id}, 32'd2);

    // Requester 0 arriving while requester 2 owns
    do_reset();
    data[15:0]  = 16'h0E01;
    data[47:32] = 16'h2222;
    req = 3'b100;
    tick();
    tick();
    req = 3'b101;
    tick();
`ifdef DISP_ARB_PRIO0_EN
    check_eq("p0_grant", {29'h0, grant}, 32'b001);
    check_eq("p0_hex", hexv(), 32'h0E01);
    check_eq("p0_owner", {30'h0, owner_id}, 32'd0);
`else
    check_eq("p0_wait_grant", {29'h0, grant}, 32'b100);
    for (int i = 4; i <= 8; i++) tick();
    check_eq("p0_wait_grant8", {29'h0, grant}, 32'b100);
    tick();
    check_eq("p0_exp_grant", {29'h0, grant}, 32'b001);
    check_eq("p0_exp_hex", hexv(), 32'h0E01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
